fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter INSTR_W, default 8, instruction word width in bits.
REQ-002 SHALL have parameter OP_W, default 4, opcode field width, located in instruction bits [INSTR_W-1 : INSTR_W-OP_W].
REQ-003 SHALL have parameter NOP_OPCODE, default 0, opcode value of NOP.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port run  input  1  fetch enable, level-sensitive.
REQ-007 SHALL have port rom_addr  output  5  program memory address, equal to registered PC.
REQ-008 SHALL have port rom_data  input  INSTR_W  instruction from program memory, combinational in rom_addr.
REQ-009 SHALL have port instr  output  INSTR_W  latched instruction register.
REQ-010 SHALL have port instr_pc  output  5  address instr was fetched from.
REQ-011 SHALL have port instr_valid  output  1  instr/instr_pc valid for downstream.
REQ-012 SHALL have port instr_ready  input  1  downstream accepts instr.
REQ-013 SHALL have port jump  input  1  redirect request, one cycle.
REQ-014 SHALL have port jump_addr  input  5  redirect target.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, ISSUE; instr_valid high only in ISSUE.
REQ-016 IDLE: run=1 -> FETCH next cycle; else stay.
REQ-017 FETCH: on clock edge SHALL load instr<=rom_data, instr_pc<=pc, pc<=next(pc), then -> ISSUE.
REQ-018 ISSUE: instr, instr_pc SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-019 ISSUE: handshake (instr_valid & instr_ready) SHALL complete transfer; -> FETCH if run=1, else IDLE.
REQ-020 Deasserting run SHALL never drop instr_valid before its handshake completes.
REQ-021 next(pc) SHALL be pc+1, except 31 -> 1; address 0 is reserved and never fetched.
REQ-022 Latency: run sampled high in IDLE -> instr_valid high 2 cycles later; steady-state throughput one instruction per 2 cycles with instr_ready held high.
REQ-023 jump=1 in any state SHALL set pc<=jump_addr (jump_addr=0 mapped to 1) and take priority over all other pc updates that cycle.
REQ-024 jump in ISSUE SHALL flush the pending instruction (instr_valid low next cycle, even if handshake occurs same cycle: transfer counts as accepted) and go FETCH if run=1, else IDLE.
REQ-025 jump in FETCH SHALL discard that fetch (instr unchanged) and remain in FETCH; jump in IDLE SHALL only update pc.
REQ-026 rom_addr SHALL be a direct copy of pc register, no combinational path from any input.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, pc=1 (rom_addr=1), instr=0, instr_pc=0, instr_valid=0.
REQ-028 Reset asserted mid-handshake SHALL drop instr_valid without completing transfer; operation resumes from address 1.
REQ-029 Deassertion SHALL be synchronised internally; first state change no earlier than second rising edge after release.

Configuration
REQ-030 Macro FETCH_NOP_SKIP_EN defined: in FETCH, rom_data with opcode field = NOP_OPCODE SHALL not be issued; pc<=next(pc), instr unchanged, stay FETCH (one cycle per skipped NOP).
REQ-031 Macro FETCH_NOP_SKIP_EN undefined: NOPs SHALL be issued like any other instruction.
REQ-032 With skip enabled, a program of only NOPs SHALL loop forever with instr_valid=0 and no hang other than that.

Verification
REQ-033 Reset, run=1, instr_ready=1, memory[1]=0x13: instr_valid first high 2 cycles after reset sync, instr=0x13, instr_pc=1.
REQ-034 instr_ready=0 for 5 cycles at instr_pc=2: instr and instr_pc stable, instr_valid high all 5 cycles; raising ready -> next instr_pc=3.
REQ-035 Run through address 31 with ready=1: next instr_pc after 31 is 1, address 0 never appears on rom_addr.
REQ-036 jump=1, jump_addr=7 during ISSUE of instr_pc=4: instr_valid low next cycle, next issued instr_pc=7; jump_addr=0 -> next instr_pc=1.
REQ-037 FETCH_NOP_SKIP_EN defined, memory[5..7]=NOP, memory[8]=non-NOP: after instr_pc=4, next issued instr_pc=8 with no valid in between; undefined: instr_pc 5,6,7 issued.
REQ-038 rst_n pulsed low during ISSUE with ready=0: instr_valid=0 and rom_addr=1 immediately, no handshake recorded.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a 5-bit PC, one-deep instruction
// register and a valid/ready handshake towards the decoder.
//
// FSM: IDLE -> FETCH -> ISSUE. FETCH latches rom_data into instr. ISSUE holds
// instr stable until it is accepted or flushed by a jump.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset, deassertion
//                    synchronised inside the block
//   run              fetch enable (level)
//   rom_addr/rom_data  program memory read port; rom_addr is the PC register
//   instr, instr_pc  issued instruction and the address it came from
//   instr_valid/instr_ready  handshake towards downstream
//   jump, jump_addr  one-cycle PC redirect; jump_addr=0 is redirected to 1
//
// Build option: define FETCH_NOP_SKIP_EN to drop NOP words (opcode field ==
// NOP_OPCODE) in FETCH instead of issuing them.
module fetch_unit #(
    parameter int INSTR_W    = 8,
    parameter int OP_W       = 4,
    parameter int NOP_OPCODE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic [4:0]         rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic [4:0]         instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               jump,
    input  logic [4:0]         jump_addr
);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

    state_t     state, state_nx;
    logic [4:0] pc, pc_nx;
    logic       load;
    logic [1:0] rst_sync;

    // Address 0 is reserved: the PC wraps 31 -> 1 and a jump to 0 lands on 1.
    function automatic logic [4:0] pc_inc(input logic [4:0] p);
        return (p == 5'd31) ? 5'd1 : p + 5'd1;
    endfunction

    logic [4:0] jump_tgt;
    assign jump_tgt = (jump_addr == 5'd0) ? 5'd1 : jump_addr;

`ifdef FETCH_NOP_SKIP_EN
    logic is_nop;
    assign is_nop = (rom_data[INSTR_W-1 -: OP_W] == OP_W'(NOP_OPCODE));
`endif

    // Reset assertion is immediate; release reaches the FSM two edges later,
    // so the first state change happens on the third edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        load     = 1'b0;
        case (state)
            IDLE:  if (run) state_nx = FETCH;
            FETCH: begin
                // A jump discards this fetch; the redirected PC is fetched next.
                if (!jump) begin
`ifdef FETCH_NOP_SKIP_EN
                    if (is_nop) begin
                        pc_nx = pc_inc(pc);
                    end else begin
                        load     = 1'b1;
                        pc_nx    = pc_inc(pc);
                        state_nx = ISSUE;
                    end
`else
                    load     = 1'b1;
                    pc_nx    = pc_inc(pc);
                    state_nx = ISSUE;
`endif
                end
            end
            ISSUE: begin
                // Jump flushes the pending word; a same-cycle handshake still
                // counts as accepted downstream.
                if (jump || instr_ready) state_nx = run ? FETCH : IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (jump) pc_nx = jump_tgt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= 5'd1;
            instr    <= '0;
            instr_pc <= 5'd0;
        end else if (!rst_sync[1]) begin
            state    <= IDLE;
            pc       <= 5'd1;
            instr    <= '0;
            instr_pc <= 5'd0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (load) begin
                instr    <= rom_data;
                instr_pc <= pc;
            end
        end
    end

    assign rom_addr    = pc;
    assign instr_valid = (state == ISSUE);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [4:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] instr;
    logic [4:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic       jump;
    logic [4:0] jump_addr;

    logic [7:0] mem [32];
    int         n_chk = 0;
    int         n_err = 0;
    int         hs    = 0;
    int         gap   = 0;
    bit         addr0_seen = 1'b0;

    always #5 clk = ~clk;

    assign rom_data = mem[rom_addr];

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump        (jump),
        .jump_addr   (jump_addr)
    );

    always @(posedge clk) if (rst_n && instr_valid && instr_ready) hs++;
    always @(negedge clk) if (rom_addr == 5'd0) addr0_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Advance at least one cycle, then until instr_valid (bounded); check the
    // issued word against the memory model.
    task automatic next_issue(input logic [4:0] exp_pc, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!instr_valid && n < 20);
        gap = n;
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_pc"},    32'(instr_pc),    32'(exp_pc));
        chk({tag, "_instr"}, 32'(instr),       32'(mem[exp_pc]));
    endtask

    initial begin
        int hs_before;
        for (int i = 0; i < 32; i++) mem[i] = 8'h12 + 8'(i);
        mem[0] = 8'hFF;
        run = 1'b1; instr_ready = 1'b1; jump = 1'b0; jump_addr = 5'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid",    32'(instr_valid), 32'd0);
        chk("rst_addr",     32'(rom_addr),    32'd1);
        chk("rst_instr",    32'(instr),       32'd0);
        chk("rst_instr_pc", 32'(instr_pc),    32'd0);

        // First issue: two sync edges, then FETCH, then ISSUE.
        tick();
        rst_n = 1'b1;
        next_issue(5'd1, "first");
        chk("first_instr13", 32'(instr), 32'h13);
        chk("first_latency", 32'(gap), 32'd4);

        // Stall at pc 2, dropping run mid-stall must not drop valid.
        next_issue(5'd2, "stall_start");
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) run = 1'b0;
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_pc",    32'(instr_pc),    32'd2);
            chk("stall_instr", 32'(instr),       32'h14);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("idle_valid", 32'(instr_valid), 32'd0);
            tick();
        end
        run = 1'b1;
        next_issue(5'd3, "resume");

        // Steady-state throughput and wrap 31 -> 1.
        for (int p = 4; p < 32; p++) begin
            next_issue(5'(p), "seq");
            chk("seq_gap", 32'(gap), 32'd2);
        end
        next_issue(5'd1, "wrap");
        chk("wrap_gap", 32'(gap), 32'd2);

        // Jump during ISSUE of pc 4 with handshake in the same cycle.
        next_issue(5'd2, "pre_jump");
        next_issue(5'd3, "pre_jump");
        next_issue(5'd4, "pre_jump");
        jump = 1'b1; jump_addr = 5'd7;
        tick();
        jump = 1'b0;
        chk("jump_flush", 32'(instr_valid), 32'd0);
        next_issue(5'd7, "jump7");
        jump = 1'b1; jump_addr = 5'd0;
        tick();
        jump = 1'b0;
        chk("jump0_flush", 32'(instr_valid), 32'd0);
        chk("jump0_addr",  32'(rom_addr),    32'd1);
        next_issue(5'd1, "jump0");

        // NOPs at 5..7.
        for (int i = 5; i <= 7; i++) mem[i] = 8'h05;
        next_issue(5'd2, "nop_pre");
        next_issue(5'd3, "nop_pre");
        next_issue(5'd4, "nop_pre");
`ifndef FETCH_NOP_SKIP_EN
        next_issue(5'd5, "nop_issue");
        next_issue(5'd6, "nop_issue");
        next_issue(5'd7, "nop_issue");
`endif
        next_issue(5'd8, "after_nop");

        // Reset during a stalled ISSUE.
        next_issue(5'd9, "pre_rst");
        instr_ready = 1'b0;
        tick();
        tick();
        hs_before = hs;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_addr",  32'(rom_addr),    32'd1);
        chk("mid_rst_instr", 32'(instr),       32'd0);
        tick();
        instr_ready = 1'b1;
        rst_n = 1'b1;
        chk("mid_rst_no_hs", 32'(hs), 32'(hs_before));
        next_issue(5'd1, "post_rst");
        chk("post_rst_latency", 32'(gap), 32'd4);

        chk("addr0_never", 32'(addr0_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
